// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN accelerator datapath blocks.
package cnn_pkg;

  localparam int unsigned CNN_WORD_SIZE = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/layer_output_serializer.sv
// Captures one parallel layer output vector and streams it out word by word,
// highest index first, flagging the final word with last_o.
module layer_output_serializer
  import cnn_pkg::*;
#(
  parameter int unsigned WORD_SIZE = CNN_WORD_SIZE,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [NUM_WORDS-1:0][WORD_SIZE-1:0] data_i,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [WORD_SIZE-1:0]                data_o,
  output logic                                last_o
);

  localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_WORDS - 1);

  ser_state_e                          r_state;
  logic [NUM_WORDS-1:0][WORD_SIZE-1:0] r_buf;
  logic [CNT_W-1:0]                    r_count;

  logic                 w_send;
  logic                 w_final;
  logic [WORD_SIZE-1:0] w_word;

  assign w_send  = (r_state == SEND);
  assign w_final = w_send && (r_count == '0) && ready_i;

  // The final beat frees the buffer, so a waiting vector can load in the same cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_count <= CNT_MAX;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_buf   <= data_i;
            r_count <= CNT_MAX;
            r_state <= SEND;
          end
        end
        SEND: begin
          if (ready_i) begin
            if (r_count == '0) begin
              if (valid_i) begin
                r_buf   <= data_i;
                r_count <= CNT_MAX;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_count <= r_count - CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Word select written as a compare mux so any NUM_WORDS, including 1, indexes cleanly.
  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (r_count == CNT_W'(i)) begin
        w_word = r_buf[i];
      end
    end
  end

  always_comb begin
    ready_o = !w_send || w_final;
    valid_o = w_send;
    last_o  = w_send && (r_count == '0);
    data_o  = w_send ? w_word : '0;
  end

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: a 4-word and a 1-word instance checked
// against a word-queue reference model.
module tb_layer_output_serializer;

  localparam int unsigned WS = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                v4 = 1'b0, r4 = 1'b0;
  logic [3:0][WS-1:0]  d4 = '0;
  logic                rdy4, vo4, last4;
  logic [WS-1:0]       do4;

  logic                v1 = 1'b0, r1 = 1'b0;
  logic [0:0][WS-1:0]  d1 = '0;
  logic                rdy1, vo1, last1;
  logic [WS-1:0]       do1;

  int total = 0;
  int bad   = 0;

  // Model state: queue of {last, word} still owed by each instance.
  logic [WS:0] q4[$];
  logic [WS:0] q1[$];
  logic e_rdy4, e_vo4, e_last4, e_rdy1, e_vo1, e_last1;
  logic [WS-1:0] e_do4, e_do1;
  logic p_acc4 = 1'b0, p_pop4 = 1'b0, p_acc1 = 1'b0, p_pop1 = 1'b0;
  logic [3:0][WS-1:0] p_d4 = '0;
  logic [WS-1:0] p_d1 = '0;

  layer_output_serializer #(.WORD_SIZE(WS), .NUM_WORDS(4)) u_dut4 (
    .clk_i(clk), .reset_i(rst), .valid_i(v4), .ready_o(rdy4), .data_i(d4),
    .valid_o(vo4), .ready_i(r4), .data_o(do4), .last_o(last4)
  );

  layer_output_serializer #(.WORD_SIZE(WS), .NUM_WORDS(1)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .valid_i(v1), .ready_o(rdy1), .data_i(d1),
    .valid_o(vo1), .ready_i(r1), .data_o(do1), .last_o(last1)
  );

  always #5 clk = ~clk;

  // One clock cycle: retire last cycle's transfers in the model, drive new inputs, form expectations.
  task automatic cyc(input logic v_4, input logic [3:0][WS-1:0] dd4, input logic rr4,
                     input logic v_1, input logic [WS-1:0] dd1, input logic rr1);
    @(posedge clk);
    if (p_pop4) void'(q4.pop_front());
    if (p_acc4) for (int i = 3; i >= 0; i--) q4.push_back({(i == 0), p_d4[i]});
    if (p_pop1) void'(q1.pop_front());
    if (p_acc1) q1.push_back({1'b1, p_d1});
    #1;
    v4 = v_4; d4 = dd4; r4 = rr4;
    v1 = v_1; d1[0] = dd1; r1 = rr1;
    #3;
    e_vo4   = (q4.size() > 0);
    e_do4   = e_vo4 ? q4[0][WS-1:0] : '0;
    e_last4 = e_vo4 && q4[0][WS];
    e_rdy4  = (q4.size() == 0) || (q4.size() == 1 && rr4);
    p_acc4  = v_4 && e_rdy4;
    p_pop4  = e_vo4 && rr4;
    p_d4    = dd4;
    e_vo1   = (q1.size() > 0);
    e_do1   = e_vo1 ? q1[0][WS-1:0] : '0;
    e_last1 = e_vo1 && q1[0][WS];
    e_rdy1  = (q1.size() == 0) || (q1.size() == 1 && rr1);
    p_acc1  = v_1 && e_rdy1;
    p_pop1  = e_vo1 && rr1;
    p_d1    = dd1;
  endtask

  task automatic clear_model();
    q4.delete(); q1.delete();
    p_acc4 = 1'b0; p_pop4 = 1'b0; p_acc1 = 1'b0; p_pop1 = 1'b0;
  endtask

  function automatic logic [3:0][WS-1:0] vec(input logic [WS-1:0] w3, input logic [WS-1:0] w2,
                                              input logic [WS-1:0] w1, input logic [WS-1:0] w0);
    logic [3:0][WS-1:0] v;
    v[3] = w3; v[2] = w2; v[1] = w1; v[0] = w0;
    return v;
  endfunction

  task automatic test_reset();
    #2;
    total++;
    if ({rdy4, vo4, last4, do4} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL reset4 got rdy=%b v=%b l=%b d=%h exp rdy=1 v=0 l=0 d=0000", rdy4, vo4, last4, do4);
    end
    total++;
    if ({rdy1, vo1, last1, do1} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL reset1 got rdy=%b v=%b l=%b d=%h exp rdy=1 v=0 l=0 d=0000", rdy1, vo1, last1, do1);
    end
    @(posedge clk); #1 rst = 1'b0;
    clear_model();
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    total++;
    if ({rdy4, vo4, last4, do4} !== {e_rdy4, e_vo4, e_last4, e_do4}) begin
      bad++;
      $display("FAIL post_reset got rdy=%b v=%b l=%b d=%h exp rdy=%b v=%b l=%b d=%h",
               rdy4, vo4, last4, do4, e_rdy4, e_vo4, e_last4, e_do4);
    end
  endtask

  task automatic test_single();
    for (int c = 0; c < 7; c++) begin
      cyc(c == 0, vec(16'h0001, 16'h0002, 16'h0003, 16'h0004), 1'b1, 1'b0, '0, 1'b1);
      total++;
      if ({rdy4, vo4, last4, do4} !== {e_rdy4, e_vo4, e_last4, e_do4}) begin
        bad++;
        $display("FAIL single c=%0d got rdy=%b v=%b l=%b d=%h exp rdy=%b v=%b l=%b d=%h",
                 c, rdy4, vo4, last4, do4, e_rdy4, e_vo4, e_last4, e_do4);
      end
    end
  endtask

  task automatic test_back_to_back();
    int beats = 0;
    for (int c = 0; c < 11; c++) begin
      cyc(c <= 4, (c == 0) ? vec(16'h0001, 16'h0002, 16'h0003, 16'h0004)
                           : vec(16'h000b, 16'h000a, 16'h0009, 16'h0008), 1'b1, 1'b0, '0, 1'b1);
      if (vo4) beats++;
      total++;
      if ({rdy4, vo4, last4, do4} !== {e_rdy4, e_vo4, e_last4, e_do4}) begin
        bad++;
        $display("FAIL b2b c=%0d got rdy=%b v=%b l=%b d=%h exp rdy=%b v=%b l=%b d=%h",
                 c, rdy4, vo4, last4, do4, e_rdy4, e_vo4, e_last4, e_do4);
      end
    end
    total++;
    if (beats != 8) begin
      bad++;
      $display("FAIL b2b_beats got %0d exp 8", beats);
    end
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 16; c++) begin
      cyc(c == 0, vec(16'h1111, 16'h2222, 16'h3333, 16'h4444), pat[c % 4], 1'b0, '0, 1'b1);
      total++;
      if ({rdy4, vo4, last4, do4} !== {e_rdy4, e_vo4, e_last4, e_do4}) begin
        bad++;
        $display("FAIL backpressure c=%0d got rdy=%b v=%b l=%b d=%h exp rdy=%b v=%b l=%b d=%h",
                 c, rdy4, vo4, last4, do4, e_rdy4, e_vo4, e_last4, e_do4);
      end
    end
  endtask

  task automatic test_hold_busy();
    for (int c = 0; c < 13; c++) begin
      cyc(c <= 6, (c == 0) ? vec(16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd)
                           : vec(16'h0c03, 16'h0c02, 16'h0c01, 16'h0c00),
          (c != 2 && c != 4), 1'b0, '0, 1'b1);
      total++;
      if ({rdy4, vo4, last4, do4} !== {e_rdy4, e_vo4, e_last4, e_do4}) begin
        bad++;
        $display("FAIL hold_busy c=%0d got rdy=%b v=%b l=%b d=%h exp rdy=%b v=%b l=%b d=%h",
                 c, rdy4, vo4, last4, do4, e_rdy4, e_vo4, e_last4, e_do4);
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int c = 0; c < 3; c++) begin
      cyc(c == 0, vec(16'h0101, 16'h0202, 16'h0303, 16'h0404), 1'b1, 1'b0, '0, 1'b1);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({rdy4, vo4, last4, do4} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL mid_reset got rdy=%b v=%b l=%b d=%h exp rdy=1 v=0 l=0 d=0000", rdy4, vo4, last4, do4);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    clear_model();
    for (int c = 0; c < 7; c++) begin
      cyc(c == 0, vec(16'h0005, 16'h0006, 16'h0007, 16'h0008), 1'b1, 1'b0, '0, 1'b1);
      total++;
      if ({rdy4, vo4, last4, do4} !== {e_rdy4, e_vo4, e_last4, e_do4}) begin
        bad++;
        $display("FAIL after_reset c=%0d got rdy=%b v=%b l=%b d=%h exp rdy=%b v=%b l=%b d=%h",
                 c, rdy4, vo4, last4, do4, e_rdy4, e_vo4, e_last4, e_do4);
      end
    end
  endtask

  task automatic test_one_word();
    logic [WS-1:0] words [3] = '{16'h0003, 16'h0007, 16'h0000};
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0, '0, 1'b1, c < 2, words[c % 3], 1'b1);
      total++;
      if ({rdy1, vo1, last1, do1} !== {e_rdy1, e_vo1, e_last1, e_do1}) begin
        bad++;
        $display("FAIL one_word c=%0d got rdy=%b v=%b l=%b d=%h exp rdy=%b v=%b l=%b d=%h",
                 c, rdy1, vo1, last1, do1, e_rdy1, e_vo1, e_last1, e_do1);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) != 0));
      total++;
      if ({rdy4, vo4, last4, do4} !== {e_rdy4, e_vo4, e_last4, e_do4}) begin
        bad++;
        $display("FAIL random4 c=%0d got rdy=%b v=%b l=%b d=%h exp rdy=%b v=%b l=%b d=%h",
                 c, rdy4, vo4, last4, do4, e_rdy4, e_vo4, e_last4, e_do4);
      end
      total++;
      if ({rdy1, vo1, last1, do1} !== {e_rdy1, e_vo1, e_last1, e_do1}) begin
        bad++;
        $display("FAIL random1 c=%0d got rdy=%b v=%b l=%b d=%h exp rdy=%b v=%b l=%b d=%h",
                 c, rdy1, vo1, last1, do1, e_rdy1, e_vo1, e_last1, e_do1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_hold_busy();
    test_mid_reset();
    test_one_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
